// File: rtl/square_acc_pipe_pkg.sv
// Shared definitions for the pipelined squaring / sum-of-squares unit.
package square_acc_pipe_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_ACC    = 1'b1;

    // Result width: full square plus accumulator guard bits.
    function automatic int unsigned calc_out_w(input int unsigned data_w,
                                               input int unsigned acc_extra);
        return 2 * data_w + acc_extra;
    endfunction

endpackage

// File: rtl/square_stage_pipe.sv
// Enable-gated multiply pipeline: squares the sample on entry and shifts
// {valid, product, mode, last} through DEPTH register stages.
module square_stage_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  mode_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [2*DATA_W-1:0]   prod_o,
    output logic                  mode_o,
    output logic                  last_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] op_c;
    logic [PROD_W-1:0] prod_c;

    // Sign-extended operand; the low PROD_W bits of its square are exact.
    always_comb begin
        op_c = PROD_W'(data_i);
        if (SIGNED && data_i[DATA_W-1]) begin
            op_c = {{DATA_W{1'b1}}, data_i};
        end
        prod_c = op_c * op_c;
    end

    generate
        if (DEPTH == 0) begin : g_pass
            assign valid_o = valid_i;
            assign prod_o  = prod_c;
            assign mode_o  = mode_i;
            assign last_o  = last_i;
        end else begin : g_pipe
            logic [DEPTH-1:0]             vld_q,  vld_d;
            logic [DEPTH-1:0]             mode_q, mode_d;
            logic [DEPTH-1:0]             last_q, last_d;
            logic [DEPTH-1:0][PROD_W-1:0] prod_q, prod_d;

            always_comb begin
                vld_d  = vld_q;
                mode_d = mode_q;
                last_d = last_q;
                prod_d = prod_q;
                if (en_i) begin
                    vld_d[0]  = valid_i;
                    mode_d[0] = mode_i;
                    last_d[0] = last_i;
                    prod_d[0] = prod_c;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        vld_d[i]  = vld_q[i-1];
                        mode_d[i] = mode_q[i-1];
                        last_d[i] = last_q[i-1];
                        prod_d[i] = prod_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= '0;
                    mode_q <= '0;
                    last_q <= '0;
                    prod_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    mode_q <= mode_d;
                    last_q <= last_d;
                    prod_q <= prod_d;
                end
            end

            assign valid_o = vld_q[DEPTH-1];
            assign prod_o  = prod_q[DEPTH-1];
            assign mode_o  = mode_q[DEPTH-1];
            assign last_o  = last_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/square_acc_pipe.sv
// Pipelined squarer with valid/ready handshake and saturating sum-of-squares
// accumulation; the final stage is the output register plus accumulator.
module square_acc_pipe
    import square_acc_pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          SIGNED    = 1'b0,
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned ACC_EXTRA = 8,
    parameter int unsigned OUT_W     = calc_out_w(DATA_W, ACC_EXTRA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              mode_i,
    input  logic              last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              sat_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = OUT_W + 1;
    localparam int unsigned DEPTH  = LATENCY - 1;

    logic              en_c;
    logic              f_valid;
    logic              f_mode;
    logic              f_last;
    logic [PROD_W-1:0] f_prod;

    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  data_q,      data_d;
    logic              sat_out_q,   sat_out_d;
    logic [OUT_W-1:0]  acc_q,       acc_d;
    logic              sat_acc_q,   sat_acc_d;

    logic [SUM_W-1:0]  sum_c;
    logic              ovf_c;
    logic [OUT_W-1:0]  clip_c;

    // Whole pipeline advances together; the input side sees the same enable.
    assign en_c       = ~out_valid_q | out_ready_i;
    assign in_ready_o = en_c;

    square_stage_pipe #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED),
        .DEPTH  (DEPTH)
    ) u_stages (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_c),
        .valid_i (in_valid_i),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .last_i  (last_i),
        .valid_o (f_valid),
        .prod_o  (f_prod),
        .mode_o  (f_mode),
        .last_o  (f_last)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sat_out_d   = sat_out_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;

        sum_c  = SUM_W'(acc_q) + SUM_W'(f_prod);
        ovf_c  = sum_c[SUM_W-1];
        clip_c = ovf_c ? '1 : sum_c[OUT_W-1:0];

        if (en_c) begin
            out_valid_d = 1'b0;
            if (f_valid) begin
                if (f_mode == MODE_SQUARE) begin
                    out_valid_d = 1'b1;
                    data_d      = OUT_W'(f_prod);
                    sat_out_d   = 1'b0;
                end else if (f_last) begin
                    // Close the frame: emit the total and restart from zero.
                    out_valid_d = 1'b1;
                    data_d      = clip_c;
                    sat_out_d   = sat_acc_q | ovf_c;
                    acc_d       = '0;
                    sat_acc_d   = 1'b0;
                end else begin
                    acc_d       = clip_c;
                    sat_acc_d   = sat_acc_q | ovf_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sat_out_q   <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sat_out_q   <= sat_out_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign sat_o       = sat_out_q;

endmodule

// File: tb/tb_square_acc_pipe.sv
// Directed bench: three square_acc_pipe instances (unsigned, signed, and
// unsigned with no guard bits) driven by identical stimulus.
module tb_square_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  data;
    logic        mode;
    logic        last;
    logic        out_ready;

    logic        rdy_u, vld_u, sat_u;
    logic [23:0] dat_u;
    logic        rdy_s, vld_s, sat_s;
    logic [23:0] dat_s;
    logic        rdy_a, vld_a, sat_a;
    logic [15:0] dat_a;

    int total = 0;
    int bad   = 0;

    logic [7:0]  vin   [8];
    logic        vmode [8];
    logic        vlast [8];
    int unsigned eu    [8];
    int unsigned es    [8];
    int unsigned ea    [8];
    logic        esat  [8];

    always #5 clk = ~clk;

    square_acc_pipe #(.DATA_W(8), .SIGNED(1'b0), .LATENCY(3), .ACC_EXTRA(8)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_u), .data_i(data),
        .mode_i(mode), .last_i(last), .out_valid_o(vld_u), .out_ready_i(out_ready),
        .data_o(dat_u), .sat_o(sat_u)
    );

    square_acc_pipe #(.DATA_W(8), .SIGNED(1'b1), .LATENCY(3), .ACC_EXTRA(8)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_s), .data_i(data),
        .mode_i(mode), .last_i(last), .out_valid_o(vld_s), .out_ready_i(out_ready),
        .data_o(dat_s), .sat_o(sat_s)
    );

    square_acc_pipe #(.DATA_W(8), .SIGNED(1'b0), .LATENCY(3), .ACC_EXTRA(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a), .data_i(data),
        .mode_i(mode), .last_i(last), .out_valid_o(vld_a), .out_ready_i(out_ready),
        .data_o(dat_a), .sat_o(sat_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int k, input logic [7:0] d, input logic m, input logic l,
                            input int unsigned u, input int unsigned s, input int unsigned a,
                            input logic sa);
        vin[k]   = d;
        vmode[k] = m;
        vlast[k] = l;
        eu[k]    = u;
        es[k]    = s;
        ea[k]    = a;
        esat[k]  = sa;
    endtask

    // Streams n beats back-to-back; beat k's result must appear 3 edges after accept.
    task automatic run_seq(input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                in_valid = 1'b1;
                data     = vin[j];
                mode     = vmode[j];
                last     = vlast[j];
            end else begin
                in_valid = 1'b0;
                data     = '0;
                mode     = 1'b0;
                last     = 1'b0;
            end
            @(negedge clk);
            chk("seq_rdy", 32'(rdy_u), 32'd1);
            if (j >= 2 && (vmode[j-2] == 1'b0 || vlast[j-2])) begin
                chk("seq_vld_u", 32'(vld_u), 32'd1);
                chk("seq_dat_u", 32'(dat_u), eu[j-2]);
                chk("seq_sat_u", 32'(sat_u), 32'd0);
                chk("seq_vld_s", 32'(vld_s), 32'd1);
                chk("seq_dat_s", 32'(dat_s), es[j-2]);
                chk("seq_vld_a", 32'(vld_a), 32'd1);
                chk("seq_dat_a", 32'(dat_a), ea[j-2]);
                chk("seq_sat_a", 32'(sat_a), 32'(esat[j-2]));
            end else begin
                chk("seq_idle_u", 32'(vld_u), 32'd0);
                chk("seq_idle_s", 32'(vld_s), 32'd0);
                chk("seq_idle_a", 32'(vld_a), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        data      = '0;
        mode      = 1'b0;
        last      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_vld", 32'(vld_u), 32'd0);
        chk("rst_dat", 32'(dat_u), 32'd0);
        chk("rst_sat", 32'(sat_u), 32'd0);
        chk("rst_rdy", 32'(rdy_u), 32'd1);
        chk("rst_dat_a", 32'(dat_a), 32'd0);
        out_ready = 1'b1;

        // Square mode, unsigned corner values (255 reads as -1 when signed)
        set_beat(0, 8'd0,   1'b0, 1'b0, 0,     0, 0,     1'b0);
        set_beat(1, 8'd1,   1'b0, 1'b0, 1,     1, 1,     1'b0);
        set_beat(2, 8'd255, 1'b0, 1'b0, 65025, 1, 65025, 1'b0);
        set_beat(3, 8'd16,  1'b0, 1'b0, 256,   256, 256, 1'b0);
        run_seq(4);

        // Square mode, signed extremes -128, -1, 127
        set_beat(0, 8'h80, 1'b0, 1'b0, 16384, 16384, 16384, 1'b0);
        set_beat(1, 8'hFF, 1'b0, 1'b0, 65025, 1,     65025, 1'b0);
        set_beat(2, 8'h7F, 1'b0, 1'b0, 16129, 16129, 16129, 1'b0);
        run_seq(3);

        // Accumulate frame 3,4,5 -> 50
        set_beat(0, 8'd3, 1'b1, 1'b0, 0,  0,  0,  1'b0);
        set_beat(1, 8'd4, 1'b1, 1'b0, 0,  0,  0,  1'b0);
        set_beat(2, 8'd5, 1'b1, 1'b1, 50, 50, 50, 1'b0);
        run_seq(3);

        // Follow-up frame proves the accumulator was cleared
        set_beat(0, 8'd2, 1'b1, 1'b1, 4, 4, 4, 1'b0);
        run_seq(1);

        // Square beat inside an open frame passes through
        set_beat(0, 8'd3, 1'b1, 1'b0, 0,  0,  0,  1'b0);
        set_beat(1, 8'd2, 1'b0, 1'b0, 4,  4,  4,  1'b0);
        set_beat(2, 8'd4, 1'b1, 1'b1, 25, 25, 25, 1'b0);
        run_seq(3);

        // Saturation only on the instance without guard bits
        set_beat(0, 8'd255, 1'b1, 1'b0, 0,      0, 0,     1'b0);
        set_beat(1, 8'd255, 1'b1, 1'b1, 130050, 2, 65535, 1'b1);
        run_seq(2);
        set_beat(0, 8'd1, 1'b1, 1'b1, 1, 1, 1, 1'b0);
        run_seq(1);

        // Reset after two open-frame beats discards the partial sum
        set_beat(0, 8'd7, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        set_beat(1, 8'd9, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        run_seq(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_vld", 32'(vld_u), 32'd0);
        chk("mrst_dat", 32'(dat_u), 32'd0);
        chk("mrst_sat_a", 32'(sat_a), 32'd0);
        set_beat(0, 8'd2, 1'b1, 1'b1, 4, 4, 4, 1'b0);
        run_seq(1);

        // Backpressure: stall 5 cycles with beat 13 waiting at the input
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            data     = 8'(10 + k);
            mode     = 1'b0;
            last     = 1'b0;
            @(negedge clk);
        end
        chk("bp_first_vld", 32'(vld_u), 32'd1);
        chk("bp_first_dat", 32'(dat_u), 32'd100);
        out_ready = 1'b0;
        data      = 8'd13;
        #1;
        chk("bp_rdy_low", 32'(rdy_u), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_vld", 32'(vld_u), 32'd1);
            chk("bp_hold_dat", 32'(dat_u), 32'd100);
            chk("bp_hold_dat_a", 32'(dat_a), 32'd100);
            chk("bp_hold_rdy", 32'(rdy_u), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_high", 32'(rdy_u), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k + 2 <= 5) begin
                in_valid = 1'b1;
                data     = 8'(10 + k + 2);
            end else begin
                in_valid = 1'b0;
                data     = '0;
            end
            @(negedge clk);
            chk("bp_drain_vld", 32'(vld_u), 32'd1);
            chk("bp_drain_dat", 32'(dat_u), 32'((10 + k) * (10 + k)));
        end
        @(negedge clk);
        chk("bp_end_vld", 32'(vld_u), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_acc_pipe.md
# square_acc_pipe

Parametrised, pipelined squaring unit with valid/ready handshake and an optional sum-of-squares accumulate mode. It succeeds the fixed 8-bit free-running squarer in the utility module set. Typical uses are power/energy estimation in DSP datapaths: per-sample |x|² in square mode, or frame energy Σx² in accumulate mode. It sits between a sample source and any downstream consumer that may apply backpressure.

## Interface
- DATA_W, 8, input sample width (2..32)
- SIGNED, 0, 1 = data_i is two's complement; 0 = unsigned
- LATENCY, 3, pipeline depth in cycles from accept to output (1..8)
- ACC_EXTRA, 8, guard bits added to the accumulator beyond 2*DATA_W
- OUT_W, 2*DATA_W+ACC_EXTRA, derived output width; not to be overridden
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept a beat this cycle
- data_i  in  DATA_W  sample
- mode_i  in  1  0 = square, 1 = accumulate; sampled per beat
- last_i  in  1  final beat of an accumulate frame; ignored when mode_i=0
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts output
- data_o  out  OUT_W  result, unsigned
- sat_o  out  1  accumulate result clipped; qualified by out_valid_o

## Operation
- Beat accepted when in_valid_i & in_ready_o. data_i, mode_i and last_i travel together through the pipeline.
- Square: SIGNED=1 sign-extends the operand; the result is always non-negative and fits in 2*DATA_W bits unsigned (−2^(DATA_W−1) squared included). data_o carries the result zero-extended to OUT_W.
- Mode 0 beat: produces one output with data_o = x², sat_o = 0. The accumulator is untouched.
- Mode 1 beat with last_i=0: adds x² into the accumulator and produces no output beat.
- Mode 1 beat with last_i=1: produces one output with data_o = acc + x². The accumulator is cleared to 0 in the same cycle.
- Saturation: if acc + x² exceeds 2^OUT_W − 1, the accumulator holds at all-ones and a sticky sat flag is set. That flag is presented as sat_o on the frame's last beat, then cleared with the accumulator.
- Mode 0 beats interleaved inside an open accumulate frame are legal. They pass through, and the frame continues.
- Pipeline: LATENCY-stage shift of {valid, x or partial product, mode, last}. The multiply may be split across stages. The accumulator add happens in the final stage.
- Stall: global enable en = ~out_valid_o | out_ready_i.
  - All stages advance only when en = 1.
  - in_ready_o = en, a combinational path from out_ready_i, which is accepted.
  - Bubbles are not compressed.
- Accumulator updates only when the final stage advances with a valid mode-1 beat.

## Timing
- Reset values: out_valid_o=0, data_o=0, sat_o=0; all stage valids, the accumulator and the sticky sat flag are 0.
- in_ready_o=1 in the first cycle after reset (out_valid_o=0).
- Beat accepted at edge t with no stall: out_valid_o=1 after edge t+LATENCY−1, i.e. visible in cycle t+LATENCY. Mode-1 non-last beats update the accumulator at that same edge.
- Throughput: 1 beat/cycle while out_ready_i=1.
- Hold: while out_valid_o=1 and out_ready_i=0, data_o, sat_o and out_valid_o are stable, and no beat is accepted.
- Simultaneous: an output accepted and a new input accepted in the same cycle is normal streaming.
- rst asserted mid-frame or mid-stall: all in-flight beats are discarded, the accumulator is cleared, outputs return to reset values at the next edge. There is no partial-frame output.

## Structure
- Shared package: a mode encoding constant (MODE_SQUARE=0, MODE_ACC=1) and a function returning OUT_W from DATA_W and ACC_EXTRA.
- One sub-module, square_stage_pipe: the LATENCY-deep signed/unsigned multiply pipeline with enable, carrying the sideband bits.
- The top level holds the accumulator, saturation logic and handshake.

## Test plan
- Reset, then DATA_W=8, SIGNED=0, mode 0: stream 0, 1, 255, 16 with out_ready_i=1 → outputs 0, 1, 65025, 256 at LATENCY cycles after each accept, back-to-back.
- SIGNED=1, mode 0: inputs −128, −1, 127 → outputs 16384, 1, 16129.
- Mode 1 frame 3, 4, 5 with last on 5 → exactly one output of 50 with sat_o=0. Then frame 2 with last → output 4, showing the accumulator was cleared.
- Backpressure: hold out_ready_i=0 for 5 cycles mid-stream → in_ready_o=0 and data_o stable throughout. No beats are lost or duplicated after release; order is preserved.
- Saturation, ACC_EXTRA=0, DATA_W=8: mode-1 beats 255, 255, last → data_o=65535, sat_o=1. The next frame (1, last) → 1, sat_o=0.
- Assert rst for 1 cycle after two non-last mode-1 beats → no output. A subsequent frame 2, last yields 4.
